cpu_axi_bridge: RTL and testbench
=================================

Name: cpu_axi_bridge

Overview:
- Downstream of the CPU top. Converts the core's two SRAM-like request/response ports (instruction and data) into one AXI master with read and write channels.
- Serialises traffic: at most one transaction outstanding at any time.
- Arbitrates data over instruction requests.
- Registers read data and returns it through a one-cycle data_ok pulse to the requester.

Parameters:
- none. Constant AXI fields (id=0, len=0, size=2, burst=INCR, lock/cache/prot=0) are tied off at the integration level and are not ports.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req  in  1  instruction read request
inst_addr  in  32  instruction byte address
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  instruction read data valid (1-cycle pulse)
data_req  in  1  data request
data_wr  in  1  1=write, 0=read
data_addr  in  32  data byte address
data_wstrb  in  4  write byte enables
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data read/write complete (1-cycle pulse)
cpu_rdata  out  32  read data, valid with either data_ok
araddr  out  32  AXI read address
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  32  AXI read data
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
awaddr  out  32  AXI write address
awvalid  out  1  AXI write address valid
awready  in  1  AXI write address ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobes
wvalid  out  1  AXI write data valid
wready  in  1  AXI write data ready
bvalid  in  1  AXI write response valid
bready  out  1  AXI write response ready

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE, all outputs 0, latched address/data/strobe/owner registers 0.
- States: IDLE, AR, R, AWW, B, RESP.
- IDLE arbitration (combinational):
  - data_addr_ok = data_req.
  - inst_addr_ok = inst_req & ~data_req.
  - No addr_ok is asserted in any other state.
- On accept: latch addr, wr, wstrb, wdata and owner (inst/data).
  - Read goes to AR; write goes to AWW.
  - inst writes do not exist.
- AR:
  - arvalid=1, araddr=latched address, held stable until arready.
  - arvalid & arready -> R.
- R:
  - rready=1.
  - On rvalid: register rdata into cpu_rdata -> RESP.
- AWW:
  - awvalid and wvalid both assert on entry; each deasserts after its own handshake (aw_done / w_done flags).
  - AW and W may complete in either order or in the same cycle.
  - Both done -> B. Flags clear on leaving.
- B:
  - bready=1.
  - bvalid -> RESP; cpu_rdata is set to 0.
- RESP:
  - Pulse the owner's data_ok for exactly one cycle -> IDLE.
  - cpu_rdata holds its value until the next RESP.
- rresp and bresp are ignored.
- Minimum latency:
  - Read: addr_ok at cycle t, arvalid at t+1; with arready at t+1 and rvalid at t+2, data_ok is at t+3.
  - Write: with aw/w ready at t+1 and bvalid at t+2, data_ok is at t+3.
- Back-to-back: the next addr_ok is possible in the cycle after RESP.
- Simultaneous inst_req and data_req: data wins; inst waits in IDLE. There is no starvation guard because the core issues data requests sporadically.
- Slave ready asserted before valid: ignored. Valid never depends on ready.
- Reset mid-transaction: return to IDLE immediately, drop all valids, no data_ok. The slave shares the same reset.

Test Plan:
- inst_req addr=0x1c000000; arready same cycle as arvalid; rvalid with rdata=0x02800c0c one cycle later -> inst_addr_ok at t, inst_data_ok at t+3 with cpu_rdata=0x02800c0c.
- inst_req and data_req (read, 0x80) both high -> data_addr_ok=1, inst_addr_ok=0; after data_data_ok, inst is granted in the following IDLE cycle.
- data write addr=0x100, wstrb=0x3, wdata=0xdeadbeef; wready 2 cycles before awready -> wvalid drops after its handshake, awvalid holds; B is entered only after both; data_data_ok one cycle after bvalid.
- arready held low for 5 cycles -> arvalid and araddr stay stable throughout; no addr_ok in that window.
- reset asserted while in R -> next cycle state=IDLE, rready=0, no data_ok; a fresh inst_req is then accepted normally.

Source files
------------

// File: rtl/cpu_axi_bridge_if.sv
// AXI read/write channel bundle between the CPU bridge and its slave.
// Fixed AXI fields (id, len, size, burst, lock, cache, prot) live at integration level.
interface cpu_axi_bridge_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rvalid,
        input  awready, wready, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid,
        output awready, wready, bvalid
    );
endinterface

// File: rtl/cpu_axi_bridge.sv
// Serialising bridge from the core's inst/data SRAM-like ports to one AXI master.
// One transaction in flight; data requests win arbitration over instruction fetches.
module cpu_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] cpu_rdata,
    cpu_axi_bridge_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AWW,
        B,
        RESP
    } state_t;

    state_t state;
    state_t state_n;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        own_data_q;
    logic        aw_done;
    logic        w_done;

    logic arvalid_c;
    logic rready_c;
    logic awvalid_c;
    logic wvalid_c;
    logic bready_c;
    logic aw_hs;
    logic w_hs;

    assign axi.araddr  = addr_q;
    assign axi.awaddr  = addr_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.arvalid = arvalid_c;
    assign axi.rready  = rready_c;
    assign axi.awvalid = awvalid_c;
    assign axi.wvalid  = wvalid_c;
    assign axi.bready  = bready_c;

    assign aw_hs = awvalid_c & axi.awready;
    assign w_hs  = wvalid_c & axi.wready;

    always_comb begin
        state_n      = state;
        data_addr_ok = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid_c    = 1'b0;
        rready_c     = 1'b0;
        awvalid_c    = 1'b0;
        wvalid_c     = 1'b0;
        bready_c     = 1'b0;
        unique case (state)
            IDLE: begin
                data_addr_ok = data_req;
                inst_addr_ok = inst_req & ~data_req;
                if (data_req) begin
                    state_n = data_wr ? AWW : AR;
                end else if (inst_req) begin
                    state_n = AR;
                end
            end
            AR: begin
                arvalid_c = 1'b1;
                if (axi.arready) begin
                    state_n = R;
                end
            end
            R: begin
                rready_c = 1'b1;
                if (axi.rvalid) begin
                    state_n = RESP;
                end
            end
            AWW: begin
                awvalid_c = ~aw_done;
                wvalid_c  = ~w_done;
                // AW and W finish independently, possibly in the same cycle
                if ((aw_done | axi.awready) & (w_done | axi.wready)) begin
                    state_n = B;
                end
            end
            B: begin
                bready_c = 1'b1;
                if (axi.bvalid) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                inst_data_ok = ~own_data_q;
                data_data_ok = own_data_q;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            own_data_q <= 1'b0;
        end else if (state == IDLE && (data_req || inst_req)) begin
            addr_q     <= data_req ? data_addr : inst_addr;
            wdata_q    <= data_req ? data_wdata : 32'h0;
            wstrb_q    <= data_req ? data_wstrb : 4'h0;
            own_data_q <= data_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == AWW && state_n == B) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == AWW) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // Writes report zero on cpu_rdata; value holds until the next completion
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata <= '0;
        end else if (state == R && axi.rvalid) begin
            cpu_rdata <= axi.rdata;
        end else if (state == B && axi.bvalid) begin
            cpu_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed and randomised checks of cpu_axi_bridge against a transaction-level model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_cpu_axi_bridge;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] cpu_rdata;

    int checks;
    int errors;

    cpu_axi_bridge_if axi();

    cpu_axi_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .cpu_rdata    (cpu_rdata),
        .axi          (axi.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        inst_addr  = 32'h0;
        data_addr  = 32'h0;
        data_wstrb = 4'h0;
        data_wdata = 32'h0;
        axi.rdata  = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
             inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0", {axi.arvalid, axi.rready,
                     axi.awvalid, axi.wvalid, axi.bready, inst_addr_ok,
                     data_addr_ok, inst_data_ok, data_data_ok});
        end
        checks++;
        if ({cpu_rdata, axi.araddr, axi.wdata, axi.wstrb} !== 100'b0) begin
            errors++;
            $display("FAIL reset_regs got %h %h %h %h exp 0", cpu_rdata,
                     axi.araddr, axi.wdata, axi.wstrb);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_inst_read();
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'h1c000000;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL ird_accept got %b%b exp 10", inst_addr_ok, data_addr_ok);
        end
        @(negedge clk);
        inst_req    = 1'b0;
        axi.arready = 1'b1;
        #1;
        checks++;
        if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h1c000000) begin
            errors++;
            $display("FAIL ird_ar got %b %h exp 1 1c000000", axi.arvalid, axi.araddr);
        end
        @(negedge clk);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'h02800c0c;
        #1;
        checks++;
        if (axi.rready !== 1'b1 || axi.arvalid !== 1'b0 || inst_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL ird_r got %b%b%b exp 100", axi.rready, axi.arvalid, inst_data_ok);
        end
        @(negedge clk);
        axi.rvalid = 1'b0;
        axi.rdata  = 32'hffffffff;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || cpu_rdata !== 32'h02800c0c) begin
            errors++;
            $display("FAIL ird_dataok got %b%b %h exp 10 02800c0c",
                     inst_data_ok, data_data_ok, cpu_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (inst_data_ok !== 1'b0 || cpu_rdata !== 32'h02800c0c) begin
            errors++;
            $display("FAIL ird_hold got %b %h exp 0 02800c0c", inst_data_ok, cpu_rdata);
        end
    endtask

    task automatic test_arbitration();
        bit seen;
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'h1c000040;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h80;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL arb_grant got d%b i%b exp d1 i0", data_addr_ok, inst_addr_ok);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            data_req    = 1'b0;
            axi.arready = 1'b1;
            axi.rvalid  = 1'b1;
            axi.rdata   = 32'h11112222;
            #1;
            if (axi.arvalid) begin
                checks++;
                if (axi.araddr !== 32'h80) begin
                    errors++;
                    $display("FAIL arb_araddr got %h exp 80", axi.araddr);
                end
            end
            checks++;
            if (inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
                errors++;
                $display("FAIL arb_inst_wait got %b%b exp 00", inst_addr_ok, inst_data_ok);
            end
            if (data_data_ok) begin
                seen = 1'b1;
                checks++;
                if (cpu_rdata !== 32'h11112222) begin
                    errors++;
                    $display("FAIL arb_drdata got %h exp 11112222", cpu_rdata);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL arb_data_timeout got 0 exp 1");
        end
        @(negedge clk);
        axi.rdata = 32'h33334444;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL arb_inst_grant got %b exp 1", inst_addr_ok);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            inst_req = 1'b0;
            #1;
            if (axi.arvalid) begin
                checks++;
                if (axi.araddr !== 32'h1c000040) begin
                    errors++;
                    $display("FAIL arb_iaraddr got %h exp 1c000040", axi.araddr);
                end
            end
            if (inst_data_ok) begin
                seen = 1'b1;
                checks++;
                if (cpu_rdata !== 32'h33334444 || data_data_ok !== 1'b0) begin
                    errors++;
                    $display("FAIL arb_irdata got %h %b exp 33334444 0",
                             cpu_rdata, data_data_ok);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL arb_inst_timeout got 0 exp 1");
        end
        idle_inputs();
    endtask

    task automatic test_write_order();
        @(negedge clk);
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_addr  = 32'h100;
        data_wstrb = 4'h3;
        data_wdata = 32'hdeadbeef;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL wr_accept got %b exp 1", data_addr_ok);
        end
        @(negedge clk);
        data_req   = 1'b0;
        data_wdata = 32'h0;
        axi.wready = 1'b1;
        #1;
        checks++;
        if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || axi.awaddr !== 32'h100 ||
            axi.wdata !== 32'hdeadbeef || axi.wstrb !== 4'h3) begin
            errors++;
            $display("FAIL wr_entry got %b%b %h %h %h exp 11 100 deadbeef 3",
                     axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb);
        end
        @(negedge clk);
        axi.wready = 1'b0;
        #1;
        checks++;
        if (axi.wvalid !== 1'b0 || axi.awvalid !== 1'b1 || axi.bready !== 1'b0) begin
            errors++;
            $display("FAIL wr_w_done got w%b aw%b b%b exp w0 aw1 b0",
                     axi.wvalid, axi.awvalid, axi.bready);
        end
        @(negedge clk);
        axi.awready = 1'b1;
        #1;
        checks++;
        if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b0 || axi.bready !== 1'b0) begin
            errors++;
            $display("FAIL wr_aw_hs got aw%b w%b b%b exp aw1 w0 b0",
                     axi.awvalid, axi.wvalid, axi.bready);
        end
        @(negedge clk);
        axi.awready = 1'b0;
        axi.bvalid  = 1'b1;
        #1;
        checks++;
        if (axi.bready !== 1'b1 || axi.awvalid !== 1'b0 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL wr_b got b%b aw%b ok%b exp b1 aw0 ok0",
                     axi.bready, axi.awvalid, data_data_ok);
        end
        @(negedge clk);
        axi.bvalid = 1'b0;
        #1;
        checks++;
        if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_dataok got %b%b %h exp 10 0",
                     data_data_ok, inst_data_ok, cpu_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse got %b exp 0", data_data_ok);
        end
        idle_inputs();
    endtask

    task automatic test_ar_stall();
        logic [31:0] a;
        a = $urandom & 32'hfffffffc;
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = a;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept got %b exp 1", inst_addr_ok);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            inst_addr = $urandom;
            data_req  = 1'b1;
            data_addr = $urandom;
            #1;
            checks++;
            if (axi.arvalid !== 1'b1 || axi.araddr !== a ||
                inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold got %b %h i%b d%b exp 1 %h i0 d0",
                         axi.arvalid, axi.araddr, inst_addr_ok, data_addr_ok, a);
            end
        end
        @(negedge clk);
        inst_req    = 1'b0;
        data_req    = 1'b0;
        axi.arready = 1'b1;
        #1;
        @(negedge clk);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = a ^ 32'h5a5a5a5a;
        #1;
        @(negedge clk);
        axi.rvalid = 1'b0;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || cpu_rdata !== (a ^ 32'h5a5a5a5a)) begin
            errors++;
            $display("FAIL stall_done got %b %h exp 1 %h",
                     inst_data_ok, cpu_rdata, a ^ 32'h5a5a5a5a);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'h1c000100;
        #1;
        @(negedge clk);
        inst_req    = 1'b0;
        axi.arready = 1'b1;
        #1;
        @(negedge clk);
        axi.arready = 1'b0;
        #1;
        checks++;
        if (axi.rready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_inr got %b exp 1", axi.rready);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (axi.rready !== 1'b0 || axi.arvalid !== 1'b0 || axi.awvalid !== 1'b0 ||
            inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle got r%b ar%b aw%b ok%b%b exp 0",
                     axi.rready, axi.arvalid, axi.awvalid, inst_data_ok, data_data_ok);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            axi.rvalid = 1'b1;
            axi.rdata  = 32'hbad0bad0;
            #1;
            checks++;
            if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_noresp got %b%b exp 00", inst_data_ok, data_data_ok);
            end
        end
        @(negedge clk);
        axi.rvalid = 1'b0;
        inst_req   = 1'b1;
        inst_addr  = 32'h1c000200;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_fresh got %b exp 1", inst_addr_ok);
        end
        @(negedge clk);
        inst_req    = 1'b0;
        axi.arready = 1'b1;
        #1;
        @(negedge clk);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'hc0ffee00;
        #1;
        @(negedge clk);
        axi.rvalid = 1'b0;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || cpu_rdata !== 32'hc0ffee00) begin
            errors++;
            $display("FAIL rstmid_done got %b %h exp 1 c0ffee00", inst_data_ok, cpu_rdata);
        end
        idle_inputs();
    endtask

    // Transaction model: requests queue up on acceptance, the slave answers in
    // order, and each completion must match the oldest outstanding request.
    task automatic test_random();
        bit          q_own[$];
        bit          q_wr[$];
        logic [31:0] q_addr[$];
        logic [3:0]  q_strb[$];
        logic [31:0] q_wdata[$];
        logic [31:0] q_rsp[$];
        bit          busy;
        bit          rd_owe;
        bit          b_owe;
        bit          aw_seen;
        bit          w_seen;
        bit          exp_d;
        bit          exp_i;
        bit          own;
        logic [31:0] rsp;
        int          done;
        int          n;
        busy = 0; rd_owe = 0; b_owe = 0; aw_seen = 0; w_seen = 0; done = 0;
        n = 600;
        for (int cyc = 0; cyc < n + 300; cyc++) begin
            if (cyc >= n && !busy) break;
            @(negedge clk);
            inst_req    = (cyc < n) && ($urandom % 3 == 0);
            inst_addr   = $urandom;
            data_req    = (cyc < n) && ($urandom % 4 == 0);
            data_wr     = $urandom % 2;
            data_addr   = $urandom;
            data_wstrb  = $urandom;
            data_wdata  = $urandom;
            axi.arready = $urandom % 2;
            axi.awready = $urandom % 2;
            axi.wready  = $urandom % 2;
            axi.rvalid  = rd_owe && ($urandom % 2);
            axi.rdata   = $urandom;
            axi.bvalid  = b_owe && ($urandom % 2);
            #1;
            exp_d = !busy && data_req;
            exp_i = !busy && inst_req && !data_req;
            checks++;
            if (data_addr_ok !== exp_d || inst_addr_ok !== exp_i) begin
                errors++;
                $display("FAIL rnd_arb cyc %0d got d%b i%b exp d%b i%b",
                         cyc, data_addr_ok, inst_addr_ok, exp_d, exp_i);
            end
            if (inst_data_ok || data_data_ok) begin
                checks++;
                if (q_own.size() == 0 || q_rsp.size() == 0 ||
                    (inst_data_ok && data_data_ok)) begin
                    errors++;
                    $display("FAIL rnd_spurious cyc %0d got %b%b exp 00",
                             cyc, inst_data_ok, data_data_ok);
                end else begin
                    own = q_own.pop_front();
                    rsp = q_rsp.pop_front();
                    void'(q_wr.pop_front());
                    void'(q_addr.pop_front());
                    void'(q_strb.pop_front());
                    void'(q_wdata.pop_front());
                    if (data_data_ok !== own || cpu_rdata !== rsp) begin
                        errors++;
                        $display("FAIL rnd_resp cyc %0d got d%b %h exp d%b %h",
                                 cyc, data_data_ok, cpu_rdata, own, rsp);
                    end
                    done++;
                end
                busy = 0;
            end
            if (exp_d || exp_i) begin
                q_own.push_back(exp_d);
                q_wr.push_back(exp_d && data_wr);
                q_addr.push_back(exp_d ? data_addr : inst_addr);
                q_strb.push_back(data_wstrb);
                q_wdata.push_back(data_wdata);
                busy = 1;
            end
            if (axi.arvalid && axi.arready) begin
                checks++;
                if (q_addr.size() == 0 || q_wr[0] || axi.araddr !== q_addr[0]) begin
                    errors++;
                    $display("FAIL rnd_ar cyc %0d got %h", cyc, axi.araddr);
                end
                rd_owe = 1;
            end
            if (axi.rvalid && axi.rready) begin
                q_rsp.push_back(axi.rdata);
                rd_owe = 0;
            end
            if (axi.awvalid && axi.awready) begin
                checks++;
                if (q_addr.size() == 0 || !q_wr[0] || aw_seen || axi.awaddr !== q_addr[0]) begin
                    errors++;
                    $display("FAIL rnd_aw cyc %0d got %h", cyc, axi.awaddr);
                end
                aw_seen = 1;
            end
            if (axi.wvalid && axi.wready) begin
                checks++;
                if (q_addr.size() == 0 || !q_wr[0] || w_seen ||
                    axi.wdata !== q_wdata[0] || axi.wstrb !== q_strb[0]) begin
                    errors++;
                    $display("FAIL rnd_w cyc %0d got %h %h", cyc, axi.wdata, axi.wstrb);
                end
                w_seen = 1;
            end
            if (aw_seen && w_seen) begin
                b_owe   = 1;
                aw_seen = 0;
                w_seen  = 0;
            end
            if (axi.bvalid && axi.bready) begin
                q_rsp.push_back(32'h0);
                b_owe = 0;
            end
        end
        checks++;
        if (busy || done < 20) begin
            errors++;
            $display("FAIL rnd_drain got busy %b done %0d exp busy 0 done>=20", busy, done);
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_inst_read();
        test_arbitration();
        test_write_order();
        test_ar_stall();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
